mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbiter sharing the core's single memory port between the instruction-fetch unit and the load/store unit. Each requester issues one transaction at a time with a level request and receives a one-cycle done pulse. The arbiter registers the winning request onto the memory port, waits for the memory acknowledge, and returns read data. A watchdog aborts transactions the memory never acknowledges. It sits inside `top` between the pipeline and the memory model that drives `mem_addr`/`mem_data`.

## Interface

- ADDR_W, 32, address width
- DATA_W, 32, data width (byte enables are DATA_W/8 bits)
- TIMEOUT, 255, maximum cycles in ISSUE before abort; must be ≥ 1
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- if_req  in  1  fetch request, level
- if_addr  in  ADDR_W  fetch address; fetch is always a full-word read
- if_rdata  out  DATA_W  fetch read data, valid while if_done=1
- if_done  out  1  one-cycle completion pulse
- if_err  out  1  with if_done, transaction timed out
- d_req  in  1  data request, level
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_be  in  DATA_W/8  byte enables
- d_rdata  out  DATA_W  load data, valid while d_done=1
- d_done  out  1  one-cycle completion pulse
- d_err  out  1  with d_done, transaction timed out
- mem_req  out  1  memory request, held until mem_ack or timeout
- mem_we, mem_addr, mem_wdata, mem_be  out  1/ADDR_W/DATA_W/DATA_W/8  memory command; stable while mem_req=1
- mem_ack  in  1  one-cycle acknowledge; mem_rdata valid in the same cycle
- mem_rdata  in  DATA_W  memory read data

## Operation

- FSM states: IDLE, ISSUE, RESP. All outputs are registered.
- IDLE: if only one requester is high, grant it. If both are high, grant the one not granted last, using the `last_d` flag, which resets to 0. So after reset, data wins the first tie. Then go to ISSUE.
- On grant:
  - latch the owner, we, addr, wdata, and be into the mem_* registers;
  - set mem_req=1;
  - clear the watchdog counter.
- A fetch grant drives mem_we=0 and mem_be=all ones.
- ISSUE: mem_req stays 1 and the mem_* command stays frozen. The counter increments each cycle.
  - mem_ack=1: capture mem_rdata into the owner's rdata, set mem_req=0, go to RESP with err=0.
  - Counter reaches TIMEOUT−1 without ack: set mem_req=0, go to RESP with err=1 and rdata=0.
  - If mem_ack arrives in that same final cycle, the ack wins.
- RESP: assert the owner's done for exactly one cycle, with err as recorded. The non-owner's done stays 0. Update last_d. Go to IDLE.
- Requester rules:
  - Hold req and its inputs stable from assertion until it samples done=1.
  - Drop req on that same edge, unless it immediately wants a new transaction.
  - Requests are ignored outside IDLE.
- mem_ack while not in ISSUE is ignored and causes no state change.
- Reset, including in the middle of a transaction, takes effect on the next edge:
  - state=IDLE, last_d=0, counter=0;
  - every output = 0, including mem_addr, mem_wdata, mem_be, and both rdata outputs.
  - An in-flight transaction is dropped without a done pulse.

## Timing

- Request high in IDLE at edge N → mem_req=1 after edge N.
- mem_ack sampled at edge M → done=1 and rdata valid for the cycle after edge M.
- IDLE is re-entered after edge M+1. A request held high is granted again at edge M+2.
- Minimum transaction, with ack in the first ISSUE cycle: 3 cycles from grant edge to the next grant. Throughput is at most one transaction per 3 cycles.
- Timeout: mem_req stays high for exactly TIMEOUT cycles, then done with err follows in the next cycle.
- if_rdata/d_rdata hold their last captured value outside done cycles. Only the done cycle is guaranteed.

## Test plan

- Single fetch: if_req=1 with if_addr=0x100; memory acks on the 2nd ISSUE cycle with 0xDEADBEEF.
  - mem_addr=0x100, mem_we=0, mem_be=0xF.
  - if_done pulses one cycle with if_rdata=0xDEADBEEF and if_err=0.
  - d_done stays 0.
- Store: d_req=1, d_we=1, d_addr=0x2004, d_wdata=0x12345678, d_be=0x3; immediate ack.
  - mem_* carries exactly these values while mem_req=1.
  - d_done occurs 2 cycles after the grant edge.
- Tie alternation: both requests held continuously for 4 transactions after reset, immediate acks.
  - Grant order is D, I, D, I.
  - Each grant is 3 cycles after the previous one.
- Timeout with TIMEOUT=4, mem_ack never asserted:
  - mem_req is high for exactly 4 cycles, then d_done=1, d_err=1, d_rdata=0.
  - The next request is served normally.
  - Also check that an ack arriving on the 4th cycle completes with err=0.
- Reset mid-ISSUE: assert reset for 1 cycle while mem_req=1.
  - All outputs are 0 after that edge, and no done pulse occurs.
  - A stale mem_ack arriving next cycle is ignored.
  - A tie afterwards grants D first.
- Spurious ack in IDLE: pulse mem_ack with no request.
  - No done pulse and no state change.

Source files
------------

// File: rtl/mem_arbiter.sv
// Memory port arbiter between instruction fetch and load/store.
// Registers the winner onto the memory port and aborts on a stuck ack.
module mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic [DATA_W-1:0]   if_rdata,
   output logic                if_done,
   output logic                if_err,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_be,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_done,
   output logic                d_err,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   input  logic                mem_ack,
   input  logic [DATA_W-1:0]   mem_rdata
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt;
   logic          last_d;
   logic          owner_d;
   logic          grant;
   logic          grant_d;
   logic          acked;
   logic          expired;

   // On a tie the requester not served last wins.
   always_comb begin
      state_n = state;
      grant   = 1'b0;
      grant_d = 1'b0;
      acked   = 1'b0;
      expired = 1'b0;
      case (state)
         IDLE: begin
            if (if_req || d_req) begin
               grant   = 1'b1;
               grant_d = d_req && (!if_req || !last_d);
               state_n = ISSUE;
            end
         end
         ISSUE: begin
            if (mem_ack) begin
               acked   = 1'b1;
               state_n = RESP;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
               expired = 1'b1;
               state_n = RESP;
            end
         end
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt       <= '0;
         last_d    <= 1'b0;
         owner_d   <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
         if_rdata  <= '0;
         if_done   <= 1'b0;
         if_err    <= 1'b0;
         d_rdata   <= '0;
         d_done    <= 1'b0;
         d_err     <= 1'b0;
      end else begin
         if_done <= 1'b0;
         if_err  <= 1'b0;
         d_done  <= 1'b0;
         d_err   <= 1'b0;
         if (grant) begin
            owner_d <= grant_d;
            mem_req <= 1'b1;
            cnt     <= '0;
            if (grant_d) begin
               mem_we    <= d_we;
               mem_addr  <= d_addr;
               mem_wdata <= d_wdata;
               mem_be    <= d_be;
            end else begin
               mem_we    <= 1'b0;
               mem_addr  <= if_addr;
               mem_wdata <= '0;
               mem_be    <= '1;
            end
         end
         if (state == ISSUE && !acked && !expired) begin
            cnt <= cnt + CW'(1);
         end
         // Timed-out transactions return zero data.
         if (acked || expired) begin
            mem_req <= 1'b0;
            if (owner_d) begin
               d_done  <= 1'b1;
               d_err   <= expired;
               d_rdata <= acked ? mem_rdata : '0;
            end else begin
               if_done  <= 1'b1;
               if_err   <= expired;
               if_rdata <= acked ? mem_rdata : '0;
            end
         end
         if (state == RESP) begin
            last_d <= owner_d;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, hand sequences and random
// transactions checked against a transaction-level model.
module tb_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic          if_done;
   logic          if_err;
   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [3:0]    d_be;
   logic [DW-1:0] d_rdata;
   logic          d_done;
   logic          d_err;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [3:0]    mem_be;
   logic          mem_ack;
   logic [DW-1:0] mem_rdata;

   int checks = 0;
   int errors = 0;
   bit m_last_d = 1'b0;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
      .if_done(if_done), .if_err(if_err),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_be(d_be), .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          ri;
      bit          rd;
      bit          we;
      logic [31:0] ia;
      logic [31:0] da;
      logic [31:0] wd;
      logic [3:0]  be;
      int          dly;
      logic [31:0] rdv;
      int          lat;
      bit          exp_d;
      bit          exp_err;
   } vec_t;

   vec_t tbl[10];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      logic [31:0] agg;
      agg = {27'd0, mem_req, mem_we, if_done, if_err, d_done} |
            {31'd0, d_err} | mem_addr | mem_wdata | {28'd0, mem_be} |
            if_rdata | d_rdata;
      chk(tag, agg, 32'd0);
   endtask

   // One transaction, started at a negedge where the DUT is IDLE or RESP.
   task automatic run(input vec_t v);
      int lat_seen;
      int hi;
      int exp_hi;
      bit stray;
      bit stable;
      logic [31:0] ea;
      logic [3:0]  ebe;
      bit          ewe;
      if_req  = v.ri;
      d_req   = v.rd;
      if_addr = v.ia;
      d_we    = v.we;
      d_addr  = v.da;
      d_wdata = v.wd;
      d_be    = v.be;
      lat_seen = 0;
      stray    = 1'b0;
      while (!mem_req && lat_seen < 10) begin
         @(negedge clk);
         lat_seen++;
         if (!mem_req && (if_done || d_done)) stray = 1'b1;
      end
      chk("grant_latency", lat_seen, v.lat);
      chk("stray_done", 32'(stray), 32'd0);
      ewe = v.exp_d ? v.we : 1'b0;
      ea  = v.exp_d ? v.da : v.ia;
      ebe = v.exp_d ? v.be : 4'hF;
      chk("mem_we", 32'(mem_we), 32'(ewe));
      chk("mem_addr", mem_addr, ea);
      chk("mem_be", 32'(mem_be), 32'(ebe));
      if (v.exp_d) chk("mem_wdata", mem_wdata, v.wd);
      hi = 0;
      stable = 1'b1;
      for (int k = 0; k < 20; k++) begin
         if (!mem_req) break;
         hi++;
         if (mem_addr !== ea || mem_be !== ebe || mem_we !== ewe)
            stable = 1'b0;
         if (k == v.dly) begin
            mem_ack   = 1'b1;
            mem_rdata = v.rdv;
         end
         @(negedge clk);
         mem_ack   = 1'b0;
         mem_rdata = $urandom;
      end
      exp_hi = (v.dly >= TO) ? TO : v.dly + 1;
      chk("mem_stable", 32'(stable), 32'd1);
      chk("mem_req_cycles", hi, exp_hi);
      chk("if_done", 32'(if_done), 32'(!v.exp_d));
      chk("d_done", 32'(d_done), 32'(v.exp_d));
      if (v.exp_d) begin
         chk("d_err", 32'(d_err), 32'(v.exp_err));
         chk("d_rdata", d_rdata, v.exp_err ? 32'd0 : v.rdv);
      end else begin
         chk("if_err", 32'(if_err), 32'(v.exp_err));
         chk("if_rdata", if_rdata, v.exp_err ? 32'd0 : v.rdv);
      end
      m_last_d = v.exp_d;
      if_req = 1'b0;
      d_req  = 1'b0;
   endtask

   function automatic vec_t mk(bit ri, bit rd, bit we, logic [31:0] ia,
                               logic [31:0] da, logic [31:0] wd,
                               logic [3:0] be, int dly, logic [31:0] rdv,
                               int lat, bit ed, bit ee);
      vec_t v;
      v.ri = ri; v.rd = rd; v.we = we; v.ia = ia; v.da = da;
      v.wd = wd; v.be = be; v.dly = dly; v.rdv = rdv; v.lat = lat;
      v.exp_d = ed; v.exp_err = ee;
      return v;
   endfunction

   initial begin
      vec_t v;
      int   p;
      int   gap;
      tbl[0] = mk(1, 0, 0, 32'h100, 0, 0, 0, 1, 32'hDEADBEEF, 1, 0, 0);
      tbl[1] = mk(0, 1, 1, 0, 32'h2004, 32'h12345678, 4'h3, 0,
                  32'h0BAD0BAD, 2, 1, 0);
      tbl[2] = mk(1, 1, 0, 32'h200, 32'h300, 0, 4'hF, 0, 32'h11, 2, 0, 0);
      tbl[3] = mk(1, 1, 0, 32'h204, 32'h304, 0, 4'hF, 0, 32'h22, 2, 1, 0);
      tbl[4] = mk(1, 1, 1, 32'h208, 32'h308, 32'hA5, 4'h1, 0, 32'h33,
                  2, 0, 0);
      tbl[5] = mk(1, 1, 1, 32'h20C, 32'h30C, 32'h5A, 4'h8, 0, 32'h44,
                  2, 1, 0);
      tbl[6] = mk(0, 1, 0, 0, 32'h400, 0, 4'hF, 5, 32'h55, 2, 1, 1);
      tbl[7] = mk(1, 0, 0, 32'h500, 0, 0, 0, 2, 32'h66, 2, 0, 0);
      tbl[8] = mk(0, 1, 0, 0, 32'h600, 0, 4'hC, 3, 32'h77, 2, 1, 0);
      tbl[9] = mk(1, 1, 0, 32'h700, 32'h800, 0, 4'hF, 4, 32'h88, 2, 0, 1);

      reset = 1'b1; if_req = 0; d_req = 0; if_addr = 0; d_we = 0;
      d_addr = 0; d_wdata = 0; d_be = 0; mem_ack = 0; mem_rdata = 0;
      repeat (2) @(negedge clk);
      chk_zero("reset_state");
      reset = 1'b0;
      m_last_d = 1'b0;

      foreach (tbl[i]) run(tbl[i]);

      @(negedge clk);
      mem_ack = 1'b1;
      mem_rdata = 32'hFFFF;
      @(negedge clk);
      mem_ack = 1'b0;
      chk("spurious_ack_req", 32'(mem_req), 32'd0);
      chk("spurious_ack_done", 32'(if_done | d_done), 32'd0);
      run(mk(1, 0, 0, 32'h900, 0, 0, 0, 0, 32'h99, 1, 0, 0));

      d_req = 1'b1; d_we = 1'b1; d_addr = 32'hA00;
      d_wdata = 32'hCAFE; d_be = 4'hF;
      repeat (2) @(negedge clk);
      chk("pre_reset_req", 32'(mem_req), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      d_req = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      chk_zero("reset_mid_issue");
      mem_ack = 1'b1;
      mem_rdata = 32'h1234;
      @(negedge clk);
      mem_ack = 1'b0;
      chk("stale_ack_req", 32'(mem_req), 32'd0);
      chk("stale_ack_done", 32'(if_done | d_done), 32'd0);
      m_last_d = 1'b0;
      for (int i = 0; i < 4; i++) begin
         v = mk(1, 1, 0, 32'hB00 + 32'(i), 32'hC00 + 32'(i), 0, 4'hF,
                0, 32'(i) + 32'hE0, (i == 0) ? 1 : 2, !m_last_d, 0);
         run(v);
      end

      for (int n = 0; n < 40; n++) begin
         p   = $urandom_range(1, 3);
         gap = $urandom_range(0, 2);
         repeat (gap) @(negedge clk);
         v.ri  = p[0];
         v.rd  = p[1];
         v.we  = 1'($urandom);
         v.ia  = $urandom;
         v.da  = $urandom;
         v.wd  = $urandom;
         v.be  = 4'($urandom);
         v.dly = $urandom_range(0, 5);
         v.rdv = $urandom;
         v.lat = (gap == 0) ? 2 : 1;
         v.exp_d   = v.rd && (!v.ri || !m_last_d);
         v.exp_err = (v.dly >= TO);
         run(v);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
